axi_lite_sram: RTL and testbench
================================

# axi_lite_sram

AXI4-Lite responder (slave) holding a word-addressed data memory. It is the far end of the load/store unit's read and write channels. It accepts read and write address/data handshakes, waits a configurable access latency, and returns the R/B responses the LSU waits on before retiring a load or store. Read and write paths are independent FSMs sharing one storage array.

## Interface
Parameters:
- `BASE`, `32'h8000_0000`: byte address of word 0.
- `DEPTH`, `4096`: number of 32-bit words; power of two.
- `RLAT`, `1`: read latency in cycles between AR handshake and data capture; 0..15.
- `WLAT`, `1`: write latency in cycles between the second of AW/W accepted and the commit; 0..15.

Ports:
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `araddr` in 32: read address.
- `arvalid` in 1: read address valid.
- `arready` out 1: read address accepted.
- `rdata` out 32: read data.
- `rresp` out 2: read response.
- `rvalid` out 1: read data valid.
- `rready` in 1: master accepts R.
- `awaddr` in 32: write address.
- `awvalid` in 1: write address valid.
- `awready` out 1: write address accepted.
- `wdata` in 32: write data.
- `wstrb` in 8: byte enables; bits [3:0] map to bytes 0..3, bits [7:4] are ignored.
- `wvalid` in 1: write data valid.
- `wready` out 1: write data accepted.
- `bresp` out 2: write response.
- `bvalid` out 1: write response valid.
- `bready` in 1: master accepts B.

## Operation
- Response codes: OKAY = 2'b00; DECERR = 2'b11 when the address is outside [BASE, BASE+4*DEPTH). Word index = (addr-BASE)>>2; addr[1:0] is ignored.
- Read FSM, states R_IDLE → R_WAIT → R_RESP:
  - R_IDLE: `arready`=1. On `arvalid`, latch the address, load the counter with RLAT, and go to R_WAIT.
  - R_WAIT: decrement the counter. At 0, capture `rdata` (0 on DECERR) and `rresp`, then go to R_RESP.
  - R_RESP: `rvalid`=1. Hold `rdata` and `rresp` stable until `rready`, then return to R_IDLE.
- Write FSM, states W_IDLE → W_WAIT → W_RESP:
  - W_IDLE: `awready` stays 1 until AW is latched; `wready` stays 1 until W is latched. AW and W may arrive in any order or in the same cycle. Once both are held, load the counter with WLAT and go to W_WAIT.
  - W_WAIT: at 0, commit the enabled bytes (no commit on DECERR) and go to W_RESP.
  - W_RESP: `bvalid`=1 with `bresp` held until `bready`, then return to W_IDLE.
- Same-word read capture and write commit in the same cycle: the read returns the pre-write value.
- Memory contents are not cleared by reset.

## Timing
- All outputs are registered. During reset every output is 0. On the first clock edge with `rst`=1, the FSMs are in their IDLE states, so `arready`, `awready` and `wready` read 1 from the following cycle.
- Read: AR handshake at edge N, so `rvalid` rises at edge N+1+RLAT. With RLAT=0, `rvalid` rises at the next edge.
- Write: with the later of AW/W accepted at edge N, `bvalid` rises at edge N+1+WLAT.
- One outstanding transaction per channel. `arready` is 0 outside R_IDLE. `awready`/`wready` are 0 once their beat is latched, until W_IDLE is re-entered.
- `rvalid` and `bvalid` never drop without `rready`/`bready`.
- Reset asserted mid-transaction: the in-flight transaction is discarded and no partial write is committed unless the commit edge has already passed.

## Configuration
- `AXI_LITE_SRAM_RAND_DELAY_EN`:
  - Defined: instead of RLAT/WLAT, each counter load takes LFSR[3:0] from a free-running 8-bit LFSR (seed 8'hA5 on reset, advancing every cycle), giving 0..15 cycles per transaction. The LFSR is used to stress the LSU wait logic.
  - Undefined: fixed RLAT/WLAT, and no LFSR hardware is present.

## Structure
- Package `axi_lite_pkg`: `resp_t` codes (OKAY, SLVERR, DECERR), `rstate_t` and `wstate_t` enums, and the `LFSR_SEED` constant.
- Sub-module `lfsr8` (taps x^8+x^6+x^5+x^4+1), instantiated only under the macro.
- The storage array is inferred inside the top; there is no separate RAM module.

## Test plan
- Write `awaddr`=8000_0010, `wdata`=DEADBEEF, `wstrb`=0F, WLAT=1, AW and W in the same cycle → `bvalid` 2 cycles later with `bresp`=00. Then read 8000_0010 → `rdata`=DEADBEEF, `rresp`=00, `rvalid` at N+2.
- Byte write `wstrb`=02, `wdata`=0000_5500 to the same word → a subsequent read returns DEAD55EF.
- AW at cycle 5, W at cycle 9 → `awready` low cycles 6–9, `bvalid` at 11 (WLAT=1), commit exactly once.
- Read 7FFF_FFFC and 8000_4000 (DEPTH=4096) → `rresp`=11, `rdata`=0. The same addresses as writes give `bresp`=11 and memory is unchanged.
- Hold `rready`=0 for 5 cycles after `rvalid` → `rvalid`/`rdata` stay stable and `arready` stays 0. The next AR is accepted the cycle after the `rready` handshake.
- Assert `rst`=0 while in W_WAIT → all outputs 0 next cycle, the target word is unchanged, and the ready signals return 1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, FSM state types and LFSR seed for axi_lite_sram
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wstate_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reseeded on reset
module lfsr8
  import axi_lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= LFSR_SEED;
    else      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/axi_lite_sram.sv
// rtl/axi_lite_sram.sv - AXI4-Lite word-addressed SRAM responder; AXI_LITE_SRAM_RAND_DELAY_EN selects LFSR-driven latencies
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          RLAT  = 1,
  parameter int          WLAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  rstate_t     rstate;
  wstate_t     wstate;
  logic [3:0]  rcnt, wcnt;
  logic [3:0]  rload, wload;
  logic [31:0] raddr, waddr, wdata_q;
  logic [3:0]  wstrb_q;
  logic        have_aw, have_w;

  // Addresses below BASE wrap to large offsets, so one unsigned compare covers both ends.
  logic [31:0]   r_off, w_off;
  logic          r_ok, w_ok;
  logic [AW-1:0] ridx, widx;
  assign r_off = raddr - BASE;
  assign w_off = waddr - BASE;
  assign r_ok  = r_off < SPAN;
  assign w_ok  = w_off < SPAN;
  assign ridx  = r_off[AW+1:2];
  assign widx  = w_off[AW+1:2];

  logic unused_bits;
  assign unused_bits = ^{wstrb[7:4], r_off[31:AW+2], r_off[1:0], w_off[31:AW+2], w_off[1:0]};

`ifdef AXI_LITE_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;
  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );
  assign rload       = lfsr_q[3:0];
  assign wload       = lfsr_q[3:0];
  assign unused_lfsr = ^lfsr_q[7:4];
`else
  assign rload = 4'(RLAT);
  assign wload = 4'(WLAT);
`endif

  logic aw_hs, w_hs, aw_held, w_held, commit;
  assign aw_hs   = awready && awvalid;
  assign w_hs    = wready && wvalid;
  assign aw_held = have_aw || aw_hs;
  assign w_held  = have_w || w_hs;
  assign commit  = rst && (wstate == W_WAIT) && (wcnt == 4'd0) && w_ok;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rcnt    <= '0;
      raddr   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arready && arvalid) begin
            raddr   <= araddr;
            rcnt    <= rload;
            arready <= 1'b0;
            rstate  <= R_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rcnt == 4'd0) begin
            rvalid <= 1'b1;
            rresp  <= r_ok ? OKAY : DECERR;
            rdata  <= r_ok ? mem[ridx] : '0;
            rstate <= R_RESP;
          end else begin
            rcnt <= rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      wcnt    <= '0;
      waddr   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            waddr   <= awaddr;
            have_aw <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb[3:0];
            have_w  <= 1'b1;
          end
          if (aw_held && w_held) begin
            wcnt    <= wload;
            awready <= 1'b0;
            wready  <= 1'b0;
            wstate  <= W_WAIT;
          end else begin
            awready <= !aw_held;
            wready  <= !w_held;
          end
        end
        W_WAIT: begin
          if (wcnt == 4'd0) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? OKAY : DECERR;
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            wstate  <= W_RESP;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb/tb_axi_lite_sram.sv - directed self-checking bench for axi_lite_sram with default parameters
module tb_axi_lite_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  axi_lite_sram dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          output int lat, output logic [1:0] resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(lat);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat,
                         output logic [31:0] d, output logic [1:0] resp);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    wait_r(lat);
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic [1:0]  resp;

    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {rdata, arready, rvalid, rresp, awready, wready, bvalid, bresp}, '0);
    rst = 1'b1;
    tick();
    chk("ready_after_release", {arready, awready, wready, rvalid, bvalid}, 5'b11100);

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, lat, resp);
    chk("wr_latency", lat, 2);
    chk("wr_bresp", resp, 2'b00);
    chk("ready_after_b", {awready, wready, bvalid}, 3'b110);
    do_read(32'h8000_0010, lat, d, resp);
    chk("rd_latency", lat, 2);
    chk("rd_data", {d, resp}, {32'hDEAD_BEEF, 2'b00});

    // Upper strobe bits must be ignored.
    do_write(32'h8000_0010, 32'h0000_5500, 8'hF2, lat, resp);
    do_read(32'h8000_0010, lat, d, resp);
    chk("byte_write", {d, resp}, {32'hDEAD_55EF, 2'b00});

    awaddr = 32'h8000_0020; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("split_aw_latched", {awready, wready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("split_aw_wait", {awready, wready, bvalid}, 3'b010);
    end
    wdata = 32'h1234_5678; wstrb = 8'h0F; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("split_both_latched", {awready, wready}, 2'b00);
    wait_b(lat);
    chk("split_latency", {lat[7:0], 6'b0, bresp}, {8'd2, 8'd0});
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(32'h8000_0020, lat, d, resp);
    chk("split_readback", {d, resp}, {32'h1234_5678, 2'b00});

    do_write(32'h8000_0000, 32'h0000_0AAA, 8'h0F, lat, resp);
    do_write(32'h8000_3FFC, 32'h0000_0BBB, 8'h0F, lat, resp);
    chk("last_word_bresp", resp, 2'b00);
    do_read(32'h7FFF_FFFC, lat, d, resp);
    chk("rd_below_base", {d, resp}, {32'h0, 2'b11});
    do_read(32'h8000_4000, lat, d, resp);
    chk("rd_past_end", {d, resp}, {32'h0, 2'b11});
    do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, lat, resp);
    chk("wr_below_base", resp, 2'b11);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, lat, resp);
    chk("wr_past_end", resp, 2'b11);
    do_read(32'h8000_0000, lat, d, resp);
    chk("word0_unchanged", {d, resp}, {32'h0000_0AAA, 2'b00});
    do_read(32'h8000_3FFC, lat, d, resp);
    chk("last_word_unchanged", {d, resp}, {32'h0000_0BBB, 2'b00});

    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    wait_r(lat);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("r_hold", {rvalid, arready, rdata}, {1'b1, 1'b0, 32'hDEAD_55EF});
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("ar_after_r_hs", {arready, rvalid}, 2'b10);
    tick();
    arvalid = 1'b0;
    chk("ar_accepted", arready, 1'b0);
    wait_r(lat);
    chk("hold_next_read", {lat[7:0], rdata}, {8'd2, 32'h1234_5678});
    rready = 1'b1; tick(); rready = 1'b0;

    do_write(32'h8000_0040, 32'h0102_0304, 8'h0F, lat, resp);
    araddr = 32'h8000_0040; arvalid = 1'b1;
    awaddr = 32'h8000_0040; wdata = 32'h0A0B_0C0D; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    chk("same_cycle_rw", {rvalid, bvalid, rdata}, {1'b1, 1'b1, 32'h0102_0304});
    rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0040, lat, d, resp);
    chk("same_cycle_after", d, 32'h0A0B_0C0D);

    do_write(32'h8000_0030, 32'h1111_1111, 8'h0F, lat, resp);
    awaddr = 32'h8000_0030; wdata = 32'hAAAA_AAAA; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_reset_outputs", {rdata, arready, rvalid, rresp, awready, wready, bvalid, bresp}, '0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_reset_release", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
    do_read(32'h8000_0030, lat, d, resp);
    chk("mid_reset_no_commit", {d, resp}, {32'h1111_1111, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
